// File: rtl/mips_exec_core_pkg.sv
// Shared constants for the execute core: ALU operation codes, opcode and
// funct encodings, and the packed decoder control word.
package mips_exec_core_pkg;

  localparam logic [3:0] ALU_SLL  = 4'd0;
  localparam logic [3:0] ALU_SRA  = 4'd1;
  localparam logic [3:0] ALU_SRL  = 4'd2;
  localparam logic [3:0] ALU_MUL  = 4'd3;
  localparam logic [3:0] ALU_DIV  = 4'd4;
  localparam logic [3:0] ALU_ADD  = 4'd5;
  localparam logic [3:0] ALU_SUB  = 4'd6;
  localparam logic [3:0] ALU_AND  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_XOR  = 4'd9;
  localparam logic [3:0] ALU_NOR  = 4'd10;
  localparam logic [3:0] ALU_SLT  = 4'd11;
  localparam logic [3:0] ALU_SLTU = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BLEZ  = 6'h06;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_COP0  = 6'h10;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL     = 6'h00;
  localparam logic [5:0] FN_SRL     = 6'h02;
  localparam logic [5:0] FN_SRA     = 6'h03;
  localparam logic [5:0] FN_SLLV    = 6'h04;
  localparam logic [5:0] FN_SRLV    = 6'h06;
  localparam logic [5:0] FN_SRAV    = 6'h07;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;
  localparam logic [5:0] FN_ERET    = 6'h18;
  localparam logic [5:0] FN_ADD     = 6'h20;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUB     = 6'h22;
  localparam logic [5:0] FN_SUBU    = 6'h23;
  localparam logic [5:0] FN_AND     = 6'h24;
  localparam logic [5:0] FN_OR      = 6'h25;
  localparam logic [5:0] FN_XOR     = 6'h26;
  localparam logic [5:0] FN_NOR     = 6'h27;
  localparam logic [5:0] FN_SLT     = 6'h2A;
  localparam logic [5:0] FN_SLTU    = 6'h2B;

  typedef struct packed {
    logic rf_dst;
    logic rf_we;
    logic branch;
    logic jump;
    logic mem_we;
    logic mem_to_reg;
    logic alu_src;
    logic shift;
    logic branch_eq;
    logic branch_leq;
    logic jump_reg;
    logic jal;
    logic usign;
    logic sys;
    logic shift_var;
    logic load_imm;
    logic store_half;
    logic exce_ret;
  } ctrl_t;

endpackage

// File: rtl/mips_exec_core_alu.sv
// 32-bit combinational ALU with secondary result for MUL/DIV.
module mips_alu
  import mips_exec_core_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic [31:0] r1,
  output logic [31:0] r2,
  output logic        eq,
  output logic        leq
);

  logic [63:0] prod;
  logic [4:0]  sh;

  // Operation select; r2 is only meaningful for MUL and DIV.
  always_comb begin
    prod = {32'b0, x} * {32'b0, y};
    sh   = y[4:0];
    r1   = '0;
    r2   = '0;
    case (op)
      ALU_SLL:  r1 = x << sh;
      ALU_SRA:  r1 = $signed(x) >>> sh;
      ALU_SRL:  r1 = x >> sh;
      ALU_MUL:  begin r1 = prod[31:0]; r2 = prod[63:32]; end
      ALU_DIV:  if (y != '0) begin r1 = x / y; r2 = x % y; end
      ALU_ADD:  r1 = x + y;
      ALU_SUB:  r1 = x - y;
      ALU_AND:  r1 = x & y;
      ALU_OR:   r1 = x | y;
      ALU_XOR:  r1 = x ^ y;
      ALU_NOR:  r1 = ~(x | y);
      ALU_SLT:  r1 = {31'b0, $signed(x) < $signed(y)};
      ALU_SLTU: r1 = {31'b0, x < y};
      default:  r1 = '0;
    endcase
  end

  assign eq  = (x == y);
  assign leq = ($signed(x) <= $signed(y));

endmodule

// File: rtl/mips_exec_core_decoder.sv
// Main instruction decoder: opcode/funct to ALU op and control flags.
module mips_decoder
  import mips_exec_core_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic [3:0] aluop,
  output ctrl_t      ctrl
);

  logic r_alu;

  // Undefined encodings fall through with every flag clear (NOP).
  always_comb begin
    ctrl  = '0;
    aluop = ALU_ADD;
    r_alu = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_SLL:  begin r_alu = 1'b1; ctrl.shift = 1'b1; aluop = ALU_SLL; end
          FN_SRA:  begin r_alu = 1'b1; ctrl.shift = 1'b1; aluop = ALU_SRA; end
          FN_SRL:  begin r_alu = 1'b1; ctrl.shift = 1'b1; aluop = ALU_SRL; end
          FN_SLLV: begin r_alu = 1'b1; ctrl.shift = 1'b1; ctrl.shift_var = 1'b1; aluop = ALU_SLL; end
          FN_SRAV: begin r_alu = 1'b1; ctrl.shift = 1'b1; ctrl.shift_var = 1'b1; aluop = ALU_SRA; end
          FN_SRLV: begin r_alu = 1'b1; ctrl.shift = 1'b1; ctrl.shift_var = 1'b1; aluop = ALU_SRL; end
          FN_ADD, FN_ADDU: begin r_alu = 1'b1; aluop = ALU_ADD; end
          FN_SUB, FN_SUBU: begin r_alu = 1'b1; aluop = ALU_SUB; end
          FN_AND:  begin r_alu = 1'b1; aluop = ALU_AND;  end
          FN_OR:   begin r_alu = 1'b1; aluop = ALU_OR;   end
          FN_XOR:  begin r_alu = 1'b1; aluop = ALU_XOR;  end
          FN_NOR:  begin r_alu = 1'b1; aluop = ALU_NOR;  end
          FN_SLT:  begin r_alu = 1'b1; aluop = ALU_SLT;  end
          FN_SLTU: begin r_alu = 1'b1; aluop = ALU_SLTU; end
          FN_JR:      ctrl.jump_reg = 1'b1;
          FN_SYSCALL: ctrl.sys      = 1'b1;
          default: ;
        endcase
        if (r_alu) begin
          ctrl.rf_dst = 1'b1;
          ctrl.rf_we  = 1'b1;
        end
      end
      OP_J:    ctrl.jump = 1'b1;
      OP_JAL:  begin ctrl.jump = 1'b1; ctrl.jal = 1'b1; ctrl.rf_we = 1'b1; end
      OP_BEQ:  begin ctrl.branch = 1'b1; ctrl.branch_eq = 1'b1; aluop = ALU_SUB; end
      OP_BNE:  begin ctrl.branch = 1'b1; aluop = ALU_SUB; end
      OP_BLEZ: begin ctrl.branch = 1'b1; ctrl.branch_leq = 1'b1; end
      OP_ADDI, OP_ADDIU: begin ctrl.alu_src = 1'b1; ctrl.rf_we = 1'b1; end
      OP_SLTI:  begin aluop = ALU_SLT;  ctrl.alu_src = 1'b1; ctrl.rf_we = 1'b1; end
      OP_SLTIU: begin aluop = ALU_SLTU; ctrl.alu_src = 1'b1; ctrl.rf_we = 1'b1; end
      OP_ANDI: begin aluop = ALU_AND; ctrl.alu_src = 1'b1; ctrl.usign = 1'b1; ctrl.rf_we = 1'b1; end
      OP_ORI:  begin aluop = ALU_OR;  ctrl.alu_src = 1'b1; ctrl.usign = 1'b1; ctrl.rf_we = 1'b1; end
      OP_XORI: begin aluop = ALU_XOR; ctrl.alu_src = 1'b1; ctrl.usign = 1'b1; ctrl.rf_we = 1'b1; end
      OP_LUI:  begin ctrl.load_imm = 1'b1; ctrl.rf_we = 1'b1; end
      OP_LW:   begin ctrl.alu_src = 1'b1; ctrl.mem_to_reg = 1'b1; ctrl.rf_we = 1'b1; end
      OP_SW:   begin ctrl.alu_src = 1'b1; ctrl.mem_we = 1'b1; end
      OP_SH:   begin ctrl.alu_src = 1'b1; ctrl.mem_we = 1'b1; ctrl.store_half = 1'b1; end
      OP_COP0: if (funct == FN_ERET) ctrl.exce_ret = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_exec_core.sv
// Execute core top: decoder, ALU and the negedge exception-PC register.
module mips_exec_core
  import mips_exec_core_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  logic [31:0] alu_x,
  input  logic [31:0] alu_y,
  input  logic [31:0] epc_d,
  input  logic        epc_we,
  output logic [3:0]  aluop,
  output logic        rf_dst,
  output logic        rf_we,
  output logic        branch,
  output logic        jump,
  output logic        mem_we,
  output logic        mem_to_reg,
  output logic        alu_src,
  output logic        shift,
  output logic        branch_eq,
  output logic        branch_leq,
  output logic        jump_reg,
  output logic        jal,
  output logic        usign,
  output logic        sys,
  output logic        shift_var,
  output logic        load_imm,
  output logic        store_half,
  output logic        exce_ret,
  output logic [31:0] alu_r1,
  output logic [31:0] alu_r2,
  output logic        alu_eq,
  output logic        alu_leq,
  output logic [31:0] epc
);

  ctrl_t ctrl;

  mips_decoder u_dec (
    .op    (op),
    .funct (funct),
    .aluop (aluop),
    .ctrl  (ctrl)
  );

  mips_alu u_alu (
    .op  (aluop),
    .x   (alu_x),
    .y   (alu_y),
    .r1  (alu_r1),
    .r2  (alu_r2),
    .eq  (alu_eq),
    .leq (alu_leq)
  );

  assign rf_dst     = ctrl.rf_dst;
  assign rf_we      = ctrl.rf_we;
  assign branch     = ctrl.branch;
  assign jump       = ctrl.jump;
  assign mem_we     = ctrl.mem_we;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign alu_src    = ctrl.alu_src;
  assign shift      = ctrl.shift;
  assign branch_eq  = ctrl.branch_eq;
  assign branch_leq = ctrl.branch_leq;
  assign jump_reg   = ctrl.jump_reg;
  assign jal        = ctrl.jal;
  assign usign      = ctrl.usign;
  assign sys        = ctrl.sys;
  assign shift_var  = ctrl.shift_var;
  assign load_imm   = ctrl.load_imm;
  assign store_half = ctrl.store_half;
  assign exce_ret   = ctrl.exce_ret;

  // Falling-edge capture so the PC updated at the rising edge is saved in the same cycle.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n)      epc <= '0;
    else if (epc_we) epc <= epc_d;
  end

endmodule

// File: tb/tb_mips_exec_core.sv
// Scoreboard bench for mips_exec_core with a table-driven reference model.
module tb_mips_exec_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  op, funct;
  logic [31:0] alu_x, alu_y, epc_d;
  logic        epc_we;
  logic [3:0]  aluop;
  logic        rf_dst, rf_we, branch, jump, mem_we, mem_to_reg, alu_src, shift;
  logic        branch_eq, branch_leq, jump_reg, jal, usign, sys, shift_var;
  logic        load_imm, store_half, exce_ret;
  logic [31:0] alu_r1, alu_r2, epc;
  logic        alu_eq, alu_leq;
  logic [3:0]  u_op;
  logic [31:0] u_r1, u_r2;
  logic        u_eq, u_leq;
  logic [17:0] flags_act;

  always #5 clk = ~clk;

  mips_exec_core dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .alu_x(alu_x), .alu_y(alu_y),
    .epc_d(epc_d), .epc_we(epc_we), .aluop(aluop), .rf_dst(rf_dst), .rf_we(rf_we),
    .branch(branch), .jump(jump), .mem_we(mem_we), .mem_to_reg(mem_to_reg),
    .alu_src(alu_src), .shift(shift), .branch_eq(branch_eq), .branch_leq(branch_leq),
    .jump_reg(jump_reg), .jal(jal), .usign(usign), .sys(sys), .shift_var(shift_var),
    .load_imm(load_imm), .store_half(store_half), .exce_ret(exce_ret),
    .alu_r1(alu_r1), .alu_r2(alu_r2), .alu_eq(alu_eq), .alu_leq(alu_leq), .epc(epc)
  );

  // MUL, DIV and codes 13-15 are never decoded, so the ALU is also exercised directly.
  mips_alu u_alu (
    .op(u_op), .x(alu_x), .y(alu_y), .r1(u_r1), .r2(u_r2), .eq(u_eq), .leq(u_leq)
  );

  assign flags_act = {rf_dst, rf_we, branch, jump, mem_we, mem_to_reg, alu_src, shift,
                      branch_eq, branch_leq, jump_reg, jal, usign, sys, shift_var,
                      load_imm, store_half, exce_ret};

  localparam int M_RFD = 1 << 17, M_WE  = 1 << 16, M_BR  = 1 << 15, M_J   = 1 << 14;
  localparam int M_MW  = 1 << 13, M_M2R = 1 << 12, M_SRC = 1 << 11, M_SH  = 1 << 10;
  localparam int M_BEQ = 1 << 9,  M_BLE = 1 << 8,  M_JR  = 1 << 7,  M_JAL = 1 << 6;
  localparam int M_US  = 1 << 5,  M_SYS = 1 << 4,  M_SV  = 1 << 3,  M_LI  = 1 << 2;
  localparam int M_SHH = 1 << 1,  M_ER  = 1;
  localparam int M_R   = M_RFD | M_WE;

  // Instruction table: opcode, funct (only significant for op 00 and 10), ALU op, flags.
  int          n_ins = 0;
  logic [5:0]  t_op [40];
  logic [5:0]  t_fn [40];
  int          t_aop[40];
  int          t_fl [40];

  task automatic add_ins(input int o, input int f, input int a, input int fl);
    t_op[n_ins]  = 6'(o);
    t_fn[n_ins]  = 6'(f);
    t_aop[n_ins] = a;
    t_fl[n_ins]  = fl;
    n_ins++;
  endtask

  task automatic ref_dec(input logic [5:0] o, input logic [5:0] f,
                         output logic [3:0] a, output logic [17:0] fl);
    a  = 4'd5;
    fl = '0;
    for (int i = 0; i < n_ins; i++) begin
      if (t_op[i] == o && ((o != 6'h00 && o != 6'h10) || t_fn[i] == f)) begin
        a  = 4'(t_aop[i]);
        fl = 18'(t_fl[i]);
      end
    end
  endtask

  task automatic ref_alu(input int a, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] r1, output logic [31:0] r2);
    logic [63:0] p;
    int unsigned s;
    s  = int'(y % 32);
    r1 = 0;
    r2 = 0;
    case (a)
      0:  r1 = x << s;
      1:  r1 = 32'($signed(x) >>> s);
      2:  r1 = x >> s;
      3:  begin p = 64'(x) * 64'(y); r1 = p[31:0]; r2 = p[63:32]; end
      4:  if (y != 0) begin r1 = x / y; r2 = x % y; end
      5:  r1 = x + y;
      6:  r1 = x - y;
      7:  r1 = x & y;
      8:  r1 = x | y;
      9:  r1 = x ^ y;
      10: r1 = ~(x | y);
      11: r1 = ($signed(x) < $signed(y)) ? 1 : 0;
      12: r1 = (x < y) ? 1 : 0;
      default: r1 = 0;
    endcase
  endtask

  typedef struct {
    logic [3:0]  aop;
    logic [17:0] fl;
    logic [31:0] r1, r2;
    logic        eq, leq;
    logic [31:0] u_r1, u_r2;
    logic [31:0] epc_pre, epc_post;
    bit          rst_mid;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_epc = 0;
  int          n_chk = 0;
  int          n_err = 0;
  bit          done  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one instruction at negedge+2 and queue what the monitor should see.
  task automatic issue(input logic [5:0] o, input logic [5:0] f, input logic [31:0] x,
                       input logic [31:0] y, input logic we, input logic [31:0] d,
                       input logic [3:0] ua, input bit rst);
    exp_t e;
    @(negedge clk);
    #2;
    op = o; funct = f; alu_x = x; alu_y = y; epc_we = we; epc_d = d; u_op = ua;
    ref_dec(o, f, e.aop, e.fl);
    ref_alu(int'(e.aop), x, y, e.r1, e.r2);
    ref_alu(int'(ua), x, y, e.u_r1, e.u_r2);
    e.eq      = (x == y);
    e.leq     = ($signed(x) <= $signed(y));
    e.epc_pre = m_epc;
    e.rst_mid = rst;
    if (rst)     m_epc = 0;
    else if (we) m_epc = d;
    e.epc_post = m_epc;
    sb.push_back(e);
    if (rst) begin
      @(posedge clk);
      #3 rst_n = 1'b0;
      @(negedge clk);
      #3;
      rst_n  = 1'b1;
      epc_we = 1'b0;
    end
  endtask

  // Monitor: combinational results and pre-edge EPC at posedge+1, EPC after the negedge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("aluop", 64'(aluop), 64'(e.aop));
        chk("flags", 64'(flags_act), 64'(e.fl));
        chk("alu_r1", 64'(alu_r1), 64'(e.r1));
        chk("alu_r2", 64'(alu_r2), 64'(e.r2));
        chk("alu_eq", 64'(alu_eq), 64'(e.eq));
        chk("alu_leq", 64'(alu_leq), 64'(e.leq));
        chk("unit_r1", 64'(u_r1), 64'(e.u_r1));
        chk("unit_r2", 64'(u_r2), 64'(e.u_r2));
        chk("epc_at_posedge", 64'(epc), 64'(e.epc_pre));
        if (e.rst_mid) begin
          #3;
          chk("epc_async_reset", 64'(epc), 64'd0);
        end
        @(negedge clk);
        #1;
        chk("epc_after_negedge", 64'(epc), 64'(e.epc_post));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0]  o, f;
    logic [31:0] x, y;
    int          k;
    rst_n = 1'b0; op = '0; funct = '0; alu_x = '0; alu_y = '0;
    epc_d = '0; epc_we = 1'b0; u_op = '0;

    add_ins(0, 'h00, 0, M_R | M_SH);          add_ins(0, 'h03, 1, M_R | M_SH);
    add_ins(0, 'h02, 2, M_R | M_SH);          add_ins(0, 'h04, 0, M_R | M_SH | M_SV);
    add_ins(0, 'h07, 1, M_R | M_SH | M_SV);   add_ins(0, 'h06, 2, M_R | M_SH | M_SV);
    add_ins(0, 'h20, 5, M_R);  add_ins(0, 'h21, 5, M_R);  add_ins(0, 'h22, 6, M_R);
    add_ins(0, 'h23, 6, M_R);  add_ins(0, 'h24, 7, M_R);  add_ins(0, 'h25, 8, M_R);
    add_ins(0, 'h26, 9, M_R);  add_ins(0, 'h27, 10, M_R); add_ins(0, 'h2A, 11, M_R);
    add_ins(0, 'h2B, 12, M_R); add_ins(0, 'h08, 5, M_JR); add_ins(0, 'h0C, 5, M_SYS);
    add_ins('h02, 0, 5, M_J);                 add_ins('h03, 0, 5, M_J | M_JAL | M_WE);
    add_ins('h04, 0, 6, M_BR | M_BEQ);        add_ins('h05, 0, 6, M_BR);
    add_ins('h06, 0, 5, M_BR | M_BLE);        add_ins('h08, 0, 5, M_SRC | M_WE);
    add_ins('h09, 0, 5, M_SRC | M_WE);        add_ins('h0A, 0, 11, M_SRC | M_WE);
    add_ins('h0B, 0, 12, M_SRC | M_WE);       add_ins('h0C, 0, 7, M_SRC | M_US | M_WE);
    add_ins('h0D, 0, 8, M_SRC | M_US | M_WE); add_ins('h0E, 0, 9, M_SRC | M_US | M_WE);
    add_ins('h0F, 0, 5, M_LI | M_WE);         add_ins('h23, 0, 5, M_SRC | M_M2R | M_WE);
    add_ins('h2B, 0, 5, M_SRC | M_MW);        add_ins('h29, 0, 5, M_SRC | M_MW | M_SHH);
    add_ins('h10, 'h18, 5, M_ER);

    @(negedge clk);
    #1 rst_n = 1'b1;

    // Directed cases, with MUL/DIV on the stand-alone ALU alongside.
    issue(6'h00, 6'h21, 32'h7FFF_FFFF, 32'h1, 1'b0, 32'h0, 4'd3, 1'b0);
    issue(6'h00, 6'h23, 32'd5, 32'd5, 1'b0, 32'h0, 4'd4, 1'b0);
    issue(6'h00, 6'h2A, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0, 4'd3, 1'b0);
    issue(6'h00, 6'h2B, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0, 4'd14, 1'b0);
    issue(6'h00, 6'h03, 32'h8000_0000, 32'd4, 1'b0, 32'h0, 4'd13, 1'b0);
    issue(6'h23, 6'h15, 32'hFFFF_FFFF, 32'd2, 1'b0, 32'h0, 4'd3, 1'b0);
    issue(6'h3F, 6'h00, 32'd17, 32'd5, 1'b0, 32'h0, 4'd4, 1'b0);
    issue(6'h04, 6'h00, 32'd9, 32'd0, 1'b0, 32'h0, 4'd4, 1'b0);
    issue(6'h05, 6'h00, 32'd9, 32'd9, 1'b0, 32'h0, 4'd15, 1'b0);
    issue(6'h06, 6'h00, 32'hFFFF_FFFE, 32'd0, 1'b0, 32'h0, 4'd1, 1'b0);
    issue(6'h00, 6'h0C, 32'h1, 32'h2, 1'b1, 32'h0000_0040, 4'd5, 1'b0);
    issue(6'h10, 6'h18, 32'h3, 32'h4, 1'b0, 32'h1234_5678, 4'd6, 1'b0);
    issue(6'h10, 6'h00, 32'h3, 32'h4, 1'b0, 32'h0, 4'd7, 1'b0);
    issue(6'h00, 6'h08, 32'h3, 32'h4, 1'b1, 32'hDEAD_BEEF, 4'd8, 1'b1);
    issue(6'h00, 6'h24, 32'hF0F0, 32'hFF00, 1'b0, 32'h55, 4'd4, 1'b0);

    // Sweep every table entry once.
    for (int i = 0; i < n_ins; i++)
      issue(t_op[i], t_fn[i], $urandom, $urandom, 1'($urandom), $urandom, 4'($urandom), 1'b0);

    // Random mix of table instructions and arbitrary encodings.
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 9) < 7) begin
        k = $urandom_range(0, n_ins - 1);
        o = t_op[k];
        f = (o == 6'h00 || o == 6'h10) ? t_fn[k] : 6'($urandom);
      end else begin
        o = 6'($urandom);
        f = 6'($urandom);
      end
      x = $urandom;
      case ($urandom_range(0, 3))
        0:       y = x;
        1:       begin x = 32'($urandom_range(0, 20)) - 10; y = 32'($urandom_range(0, 20)) - 10; end
        default: y = $urandom;
      endcase
      issue(o, f, x, y, 1'($urandom), $urandom, 4'($urandom), ($urandom_range(0, 19) == 0));
    end

    @(negedge clk);
    #2 epc_we = 1'b0;
    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mips_exec_core.md
# mips_exec_core

Single-cycle MIPS datapath core: main decoder, 32-bit ALU and the exception-PC (EPC) holding register. Sits between instruction fetch/register file and memory/PC-select logic of the CPU top level. Decoder and ALU are purely combinational. EPC is the only state; it loads on the falling clock edge so the new PC from the rising edge is captured within the same cycle.

## Interface
- No parameters; data width fixed at 32.
- `clk` in, 1: system clock; EPC samples on negedge.
- `rst_n` in, 1: asynchronous, active-low reset; clears EPC.
- `op` in, 6: instruction[31:26].
- `funct` in, 6: instruction[5:0].
- `alu_x`, `alu_y` in, 32 each: ALU operands. For shifts, x is the value and y[4:0] is the amount.
- `epc_d` in, 32: next-PC value to save.
- `epc_we` in, 1: interrupt-taken strobe.
- `aluop` out, 4: decoded ALU operation; also drives the internal ALU.
- Decoder flags, each out 1: `rf_dst`, `rf_we`, `branch`, `jump`, `mem_we`, `mem_to_reg`, `alu_src`, `shift`, `branch_eq`, `branch_leq`, `jump_reg`, `jal`, `usign`, `sys`, `shift_var`, `load_imm`, `store_half`, `exce_ret`.
- `alu_r1`, `alu_r2` out, 32 each: primary and secondary results.
- `alu_eq` out, 1: x==y.
- `alu_leq` out, 1: signed x<=y.
- `epc` out, 32: saved exception PC.

## Operation
- **ALU ops** (x=`alu_x`, y=`alu_y`; `alu_r2`=0 unless stated):
  - 0 SLL: x<<y[4:0].
  - 1 SRA: arithmetic x>>>y[4:0].
  - 2 SRL: logical x>>y[4:0].
  - 3 MUL: unsigned 64-bit product; r1=low word, r2=high word.
  - 4 DIV: unsigned; r1=quotient, r2=remainder. y=0 gives r1=r2=0.
  - 5 ADD, 6 SUB: modulo 2^32, no overflow trap.
  - 7 AND, 8 OR, 9 XOR, 10 NOR.
  - 11 SLT: signed compare, result 0/1.
  - 12 SLTU: unsigned compare, result 0/1.
  - 13–15: r1=0.
  - `alu_eq` and `alu_leq` are valid for every aluop.
- **Decoder, R-type (op=0)**. All R-type ALU instructions set rf_dst=1 and rf_we=1.
  - sll 00, sra 03, srl 02: shift=1, aluop 0/1/2.
  - sllv 04, srav 07, srlv 06: shift=1, shift_var=1.
  - add/addu 20/21: ADD. sub/subu 22/23: SUB.
  - and 24, or 25, xor 26, nor 27, slt 2A, sltu 2B: corresponding aluop.
  - jr 08: jump_reg=1 only.
  - syscall 0C: sys=1 only.
- **Decoder, I/J-type (op in hex)**:
  - j 02: jump.
  - jal 03: jump, jal, rf_we.
  - beq 04: branch, branch_eq, SUB.
  - bne 05: branch, SUB.
  - blez 06: branch, branch_leq.
  - addi/addiu 08/09: ADD, alu_src, rf_we.
  - slti 0A: SLT, alu_src, rf_we.
  - sltiu 0B: SLTU, alu_src, rf_we.
  - andi/ori/xori 0C/0D/0E: AND/OR/XOR, alu_src, usign, rf_we.
  - lui 0F: load_imm, rf_we.
  - lw 23: ADD, alu_src, mem_to_reg, rf_we.
  - sw 2B: ADD, alu_src, mem_we.
  - sh 29: ADD, alu_src, mem_we, store_half.
  - eret: op 10 with funct 18: exce_ret.
- Flags not listed are 0, and aluop defaults to ADD. Any undefined op/funct yields all flags 0 (NOP); it never writes registers or memory.
- **EPC**: at each negedge clk with epc_we=1, epc<=epc_d; otherwise epc holds.

## Timing
- Decoder and ALU outputs are combinational, zero latency, settling within the same cycle as `op`/`funct`/operands.
- EPC latency is half a cycle: epc_d presented during the high phase appears on `epc` after the following falling edge.
- rst_n low forces epc=0 immediately, regardless of clk. Reset overrides a simultaneous epc_we. Release is synchronous-safe at the next negedge.
- Reset does not affect the combinational outputs.

## Structure
- Shared package: ALU op localparams (ALU_SLL..ALU_SLTU) and opcode/funct constants.
- Natural sub-modules:
  - `mips_alu`: combinational.
  - `mips_decoder`: combinational.
  - EPC as an inline negedge always block with async clear.

## Test plan
- **ALU**:
  - ADD 7FFFFFFF+1 gives r1=80000000.
  - SUB 5-5 gives r1=0, eq=1.
  - SLT FFFFFFFF vs 1 gives 1; SLTU of the same pair gives 0.
  - SRA 80000000 by 4 gives F8000000.
- **MUL/DIV**:
  - FFFFFFFF*2 gives r1=FFFFFFFE, r2=00000001.
  - DIV 17/5 gives r1=3, r2=2.
  - DIV by 0 gives r1=r2=0.
- **Decoder sweep**, every listed instruction against the table:
  - lw gives aluop=5, alu_src, mem_to_reg, rf_we, all others 0.
  - op=3F gives all flags 0.
- **Branch flags**:
  - beq gives branch=1, branch_eq=1.
  - bne gives branch=1, branch_eq=0.
  - blez with x=FFFFFFFE, y=0 gives leq=1.
- **EPC**:
  - epc_d=0000_0040 with epc_we high over a negedge gives epc=40 after that negedge, not at the posedge.
  - epc_we low, new epc_d gives hold.
- **Reset**: assert rst_n=0 mid-high-phase with epc_we=1 gives epc=0 immediately and stays 0 through the negedge.
